// File: rtl/switch_input_conditioner.sv
// Keypad front end: per-switch 2-flop synchroniser and debounce counter,
// plus single-cycle press strobes (anysw, codesw, multi) for the lock controller.
module switch_input_conditioner #(
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rawsw,
    input  logic [1:0] selsw,
    output logic       codesw,
    output logic       anysw,
    output logic [3:0] swdb,
    output logic       multi
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       rise;
    logic [2:0]       rise_count;

    // A rise is the edge on which a pressed level completes qualification.
    always_comb begin
        rise       = '0;
        rise_count = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rise[i]    = s2[i] & ~swdb[i] & (cnt[i] == CNT_MAX);
            rise_count = rise_count + 3'(rise[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= '0;
            s2     <= '0;
            swdb   <= '0;
            anysw  <= 1'b0;
            multi  <= 1'b0;
            codesw <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= rawsw;
            s2 <= s1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2[i] == swdb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    swdb[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            anysw  <= |rise;
            multi  <= (rise_count >= 3'd2);
            codesw <= rise[selsw] & (rise_count == 3'd1);
        end
    end

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Directed bench: expected strobe events are queued when stimulus is applied
// and compared when the DUT reaches that clock edge; strobes must be 0 elsewhere.
module tb_switch_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rawsw;
    logic [1:0] selsw;
    logic       codesw;
    logic       anysw;
    logic [3:0] swdb;
    logic       multi;

    typedef struct {
        int unsigned cyc;
        logic        a;
        logic        c;
        logic        m;
        logic [3:0]  db;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc     = 0;
    int          tests   = 0;
    int          fails   = 0;
    int          npulse  = 0;
    bit          mon_en  = 1'b0;
    logic [3:0]  exp_db  = '0;

    switch_input_conditioner #(.DB_CYCLES(8), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .rawsw  (rawsw),
        .selsw  (selsw),
        .codesw (codesw),
        .anysw  (anysw),
        .swdb   (swdb),
        .multi  (multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("anysw", {3'b0, anysw}, {3'b0, e.a});
                chk("codesw", {3'b0, codesw}, {3'b0, e.c});
                chk("multi", {3'b0, multi}, {3'b0, e.m});
                chk("swdb", swdb, e.db);
            end else begin
                chk("idle_strobes", {1'b0, anysw, codesw, multi}, 4'b0000);
            end
            if (anysw === 1'b1) npulse++;
        end
    end

    // Change the raw switches cleanly and queue the resulting debounce event.
    task automatic apply(input logic [3:0] nraw, input logic [1:0] sel);
        logic [3:0] r;
        logic [3:0] f;
        int         n;
        @(negedge clk);
        r = nraw & ~exp_db;
        f = ~nraw & exp_db;
        n = $countones(r);
        rawsw = nraw;
        selsw = sel;
        if ((r | f) != 4'b0000)
            sb.push_back('{cyc + 10, (n > 0), (r[sel] && n == 1), (n >= 2), nraw});
        exp_db = nraw;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        int          base;
        int unsigned d;
        logic [3:0]  pat [5];

        // 1: reset with all keys held, then release.
        reset = 1'b0;
        rawsw = 4'b1111;
        selsw = 2'd0;
        repeat (3) @(posedge clk);
        #2;
        mon_en = 1'b1;
        chk("reset_anysw", {3'b0, anysw}, 4'b0000);
        chk("reset_codesw", {3'b0, codesw}, 4'b0000);
        chk("reset_multi", {3'b0, multi}, 4'b0000);
        chk("reset_swdb", swdb, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back('{cyc + 10, 1'b1, 1'b0, 1'b1, 4'b1111});
        exp_db = 4'b1111;
        repeat (14) @(negedge clk);
        apply(4'b0000, 2'd0);

        // 2: selected key pressed alone.
        apply(4'b0100, 2'd2);
        // 3: another key pressed while one held, not selected.
        apply(4'b1100, 2'd0);
        apply(4'b0000, 2'd0);

        // 4: bounce on key 1; only the final steady press strobes.
        pat[0] = 4'b0010; pat[1] = 4'b0000; pat[2] = 4'b0010;
        pat[3] = 4'b0010; pat[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rawsw = pat[i];
        end
        apply(4'b0010, 2'd1);
        apply(4'b0000, 2'd1);

        // 5: hold 40 cycles, release, press again: exactly two pulses.
        base = npulse;
        apply(4'b0001, 2'd0);
        repeat (40) @(negedge clk);
        apply(4'b0000, 2'd0);
        apply(4'b0001, 2'd0);
        tests++;
        assert (npulse - base == 2) else begin
            fails++;
            $error("FAIL held_key_pulses: observed %0d expected 2", npulse - base);
        end
        apply(4'b0000, 2'd0);

        // 6: reset at count 5 of a debounce restarts qualification.
        @(negedge clk);
        rawsw = 4'b0001;
        selsw = 2'd0;
        d = cyc;
        while (cyc != d + 7) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.push_back('{cyc + 10, 1'b1, 1'b1, 1'b0, 4'b0001});
        exp_db = 4'b0001;

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
